// File: rtl/seq_booth_multiplier_if.sv
// Handshake bundle for the sequential Booth multiplier: operand side and product side.
interface seq_booth_multiplier_if #(
    parameter int N = 32
);
    logic           in_valid;
    logic           in_ready;
    logic           is_signed;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out;

    modport master (
        output in_valid, is_signed, a, b, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, is_signed, a, b, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/seq_booth_multiplier.sv
// Multi-cycle radix-2 Booth multiplier, one add/sub + shift per clock, signed or unsigned per op.
module seq_booth_multiplier #(
    parameter int N = 32
) (
    input logic                  clk,
    input logic                  rst,
    seq_booth_multiplier_if.slave bus
);
    localparam int M  = N + 1;
    localparam int CW = $clog2(M + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [M-1:0]   mcand;
    logic [M-1:0]   acc_a;
    logic [M-1:0]   acc_q;
    logic           q_m1;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] product;

    logic [M-1:0]   a_ext;
    logic [M-1:0]   b_ext;
    logic [M-1:0]   sum;
    logic [M-1:0]   a_shift;
    logic [M-1:0]   q_shift;
    logic           last_step;

    // One extra bit lets unsigned operands ride the signed Booth datapath unchanged.
    assign a_ext     = {bus.is_signed & bus.a[N-1], bus.a};
    assign b_ext     = {bus.is_signed & bus.b[N-1], bus.b};
    assign last_step = (cnt == CW'(M - 1));

    always_comb begin
        sum = acc_a;
        unique case ({acc_q[0], q_m1})
            2'b01:   sum = acc_a + mcand;
            2'b10:   sum = acc_a - mcand;
            default: sum = acc_a;
        endcase
        a_shift = {sum[M-1], sum[M-1:1]};
        q_shift = {sum[0], acc_q[M-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_next = CALC;
            CALC:    if (last_step)     state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The product register is separate from the work registers so out stays put after DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            acc_a   <= '0;
            acc_q   <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand <= a_ext;
                        acc_a <= '0;
                        acc_q <= b_ext;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc_a <= a_shift;
                    acc_q <= q_shift;
                    q_m1  <= acc_q[0];
                    cnt   <= cnt + CW'(1);
                    if (last_step) begin
                        product <= {a_shift[N-2:0], q_shift};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out       = product;
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed and random checks of the Booth multiplier at N=8 and N=32 against a plain a*b model.
module tb_seq_booth_multiplier;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_booth_multiplier_if #(.N(8))  bus8 ();
    seq_booth_multiplier_if #(.N(32)) bus32 ();

    seq_booth_multiplier #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    seq_booth_multiplier #(.N(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb8  [$];
    logic [63:0] sb32 [$];

    function automatic logic [63:0] model(input bit wide, input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint pa;
        longint pb;
        longint p;
        if (wide) begin
            pa = s ? longint'($signed(a)) : longint'(a);
            pb = s ? longint'($signed(b)) : longint'(b);
        end else begin
            pa = s ? longint'($signed(a[7:0])) : longint'(a[7:0]);
            pb = s ? longint'($signed(b[7:0])) : longint'(b[7:0]);
        end
        p = pa * pb;
        return wide ? 64'(p) : {48'b0, p[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge with in_valid dropped.
    task automatic applyStimulus(input bit wide, input logic [31:0] a, input logic [31:0] b, input logic s);
        int n = 0;
        if (wide) begin
            bus32.a = a; bus32.b = b; bus32.is_signed = s; bus32.in_valid = 1'b1;
        end else begin
            bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.is_signed = s; bus8.in_valid = 1'b1;
        end
        while (n < 100 && !(wide ? bus32.in_ready : bus8.in_ready)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checkOutput("accept_timeout", 64'(n), 64'd0);
        end else if (wide) begin
            sb32.push_back(model(1'b1, a, b, s));
        end else begin
            sb8.push_back(model(1'b0, a, b, s));
        end
        @(negedge clk);
        bus8.in_valid  = 1'b0;
        bus32.in_valid = 1'b0;
    endtask

    task automatic waitValid(input bit wide, input bit stall, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 200) begin
            if ((wide ? bus32.out_valid : bus8.out_valid) && (!stall || $urandom_range(0, 2) == 0)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (!ok) checkOutput("valid_timeout", 64'(n), 64'd0);
    endtask

    task automatic collectResult(input bit wide, input bit stall, input string tag);
        bit          ok;
        logic [63:0] expected;
        waitValid(wide, stall, ok);
        if (ok) begin
            if ((wide ? sb32.size() : sb8.size()) == 0) begin
                checkOutput({tag, "_unexpected"}, 64'd1, 64'd0);
            end else begin
                expected = wide ? sb32.pop_front() : sb8.pop_front();
                checkOutput(tag, wide ? bus32.out : {48'b0, bus8.out}, expected);
            end
            if (wide) bus32.out_ready = 1'b1; else bus8.out_ready = 1'b1;
            @(negedge clk);
            bus8.out_ready  = 1'b0;
            bus32.out_ready = 1'b0;
        end
    endtask

    initial begin
        bit          ok;
        logic [63:0] expected;

        rst = 1'b1;
        bus8.in_valid = 1'b0;  bus8.is_signed = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.out_ready = 1'b0;
        bus32.in_valid = 1'b0; bus32.is_signed = 1'b0; bus32.a = '0; bus32.b = '0; bus32.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_flags8", {62'b0, bus8.in_ready, bus8.out_valid}, 64'b10);
        checkOutput("reset_out8", {48'b0, bus8.out}, 64'd0);
        checkOutput("reset_flags32", {62'b0, bus32.in_ready, bus32.out_valid}, 64'b10);
        checkOutput("reset_out32", bus32.out, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] signed and unsigned corners");
        applyStimulus(0, 32'hFF, 32'hFF, 1); collectResult(0, 0, "s_ff_ff");
        applyStimulus(0, 32'h80, 32'h80, 1); collectResult(0, 0, "s_80_80");
        applyStimulus(0, 32'h80, 32'h7F, 1); collectResult(0, 0, "s_80_7f");
        applyStimulus(0, 32'hFF, 32'hFF, 0); collectResult(0, 0, "u_ff_ff");
        applyStimulus(0, 32'h80, 32'h02, 0); collectResult(0, 0, "u_80_02");
        applyStimulus(0, 32'h00, 32'hAB, 0); collectResult(0, 0, "u_00_ab");

        $display("[TB] latency and handshake");
        bus8.a = 8'h5A; bus8.b = 8'hC3; bus8.is_signed = 1'b1; bus8.in_valid = 1'b1;
        expected = model(0, 32'h5A, 32'hC3, 1);
        checkOutput("lat_ready", {63'b0, bus8.in_ready}, 64'd1);
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            bus8.in_valid = 1'b0;
            checkOutput($sformatf("lat_busy%0d", j), {62'b0, bus8.in_ready, bus8.out_valid}, 64'b00);
        end
        @(negedge clk);
        checkOutput("lat_valid", {62'b0, bus8.in_ready, bus8.out_valid}, 64'b01);
        checkOutput("lat_out", {48'b0, bus8.out}, expected);
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        checkOutput("lat_release", {62'b0, bus8.in_ready, bus8.out_valid}, 64'b10);

        $display("[TB] backpressure");
        applyStimulus(0, 32'hB7, 32'h6D, 0);
        waitValid(0, 0, ok);
        if (ok) begin
            expected = sb8.pop_front();
            checkOutput("bp_first", {48'b0, bus8.out}, expected);
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                checkOutput("bp_hold", {47'b0, bus8.out_valid, bus8.out}, {47'b0, 1'b1, expected[15:0]});
            end
            bus8.out_ready = 1'b1;
            @(negedge clk);
            bus8.out_ready = 1'b0;
            checkOutput("bp_release", {63'b0, bus8.out_valid}, 64'd0);
        end

        $display("[TB] busy ignore");
        applyStimulus(0, 32'h13, 32'h0B, 0);
        @(negedge clk);
        bus8.a = 8'hEE; bus8.b = 8'h77; bus8.is_signed = 1'b1; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        collectResult(0, 0, "busy_result");
        for (int j = 0; j < 12; j++) begin
            checkOutput("busy_noexec", {62'b0, bus8.in_ready, bus8.out_valid}, 64'b10);
            @(negedge clk);
        end

        $display("[TB] reset mid-operation");
        applyStimulus(0, 32'h7F, 32'h81, 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_flags", {62'b0, bus8.in_ready, bus8.out_valid}, 64'b10);
        checkOutput("rst_out", {48'b0, bus8.out}, 64'd0);
        sb8.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_no_spurious", {63'b0, bus8.out_valid}, 64'd0);
        applyStimulus(0, 32'h7F, 32'h81, 1); collectResult(0, 0, "post_rst");

        $display("[TB] random N=8");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(0, $urandom, $urandom, 1'($urandom_range(0, 1)));
            collectResult(0, 1, "rand8");
        end

        $display("[TB] random N=32");
        applyStimulus(1, 32'h8000_0000, 32'h8000_0000, 1); collectResult(1, 0, "s32_min_min");
        applyStimulus(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0); collectResult(1, 0, "u32_max_max");
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            collectResult(1, 1, "rand32");
        end

        checkOutput("sb8_drained", 64'(sb8.size()), 64'd0);
        checkOutput("sb32_drained", 64'(sb32.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
